// File: rtl/bloom_ctrl_if.sv
// Request/response and BRAM port bundle for the Bloom filter sequencer.
// master = requester, slave = sequencer, bram = dual-port bit array.
interface bloom_ctrl_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_HASH   = 4
);
  logic                         in_valid;
  logic                         in_ready;
  logic [1:0]                   in_op;
  logic [NUM_HASH*ADDR_WIDTH-1:0] in_idx;
  logic                         out_valid;
  logic                         out_ready;
  logic                         out_hit;
  logic [1:0]                   out_op;
  logic [ADDR_WIDTH-1:0]        bram_addr0;
  logic [ADDR_WIDTH-1:0]        bram_addr1;
  logic                         bram_we0;
  logic                         bram_we1;
  logic                         bram_din0;
  logic                         bram_din1;
  logic                         bram_dout0;
  logic                         bram_dout1;

  modport master (
    output in_valid, in_op, in_idx, out_ready,
    input  in_ready, out_valid, out_hit, out_op
  );

  modport slave (
    input  in_valid, in_op, in_idx, out_ready, bram_dout0, bram_dout1,
    output in_ready, out_valid, out_hit, out_op,
    output bram_addr0, bram_addr1, bram_we0, bram_we1, bram_din0, bram_din1
  );

  modport bram (
    input  bram_addr0, bram_addr1, bram_we0, bram_we1, bram_din0, bram_din1,
    output bram_dout0, bram_dout1
  );
endinterface

// File: rtl/bloom_ctrl.sv
// Bloom filter operation sequencer: query, insert (test-and-set) and clear,
// issuing two bit indices per pass over a dual-port 1-bit BRAM.
//
// state   | meaning
// IDLE    | ready for a request
// ISSUE   | one pass per cycle, two indices per pass
// CLEAR   | write 0 to two addresses per cycle until the array is swept
// WAIT    | absorb the final read return
// RESP    | hold response until out_ready
module bloom_ctrl #(
  parameter int BIT_ARRAY_SIZE = 1024,
  parameter int ADDR_WIDTH     = $clog2(BIT_ARRAY_SIZE),
  parameter int NUM_HASH       = 4
) (
  input logic         clk,
  input logic         rst_n,
  bloom_ctrl_if.slave bus
);
  localparam int P     = (NUM_HASH + 1) / 2;
  localparam int PAD_W = 2 * P * ADDR_WIDTH;
  localparam bit K_ODD = (NUM_HASH % 2) == 1;
  localparam int PW    = $clog2(P + 1);
  localparam int CNT_W = (ADDR_WIDTH > PW) ? ADDR_WIDTH : PW;
  localparam logic [CNT_W-1:0] PASS_LAST = CNT_W'(P - 1);
  localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'(BIT_ARRAY_SIZE / 2 - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_CLEAR, S_WAIT, S_RESP} state_t;

  state_t                r_state;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic                  r_out_hit;
  logic [1:0]            r_out_op;
  logic [1:0]            r_op;
  logic                  r_ins;
  logic [PAD_W-1:0]      r_idx;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_acc;
  logic                  r_pass_vld;
  logic                  r_port1_vld;
  logic                  r_rd_vld;
  logic                  r_rd_use1;
  logic [ADDR_WIDTH-1:0] r_addr0;
  logic [ADDR_WIDTH-1:0] r_addr1;
  logic                  r_we0;
  logic                  r_we1;
  logic                  r_din0;
  logic                  r_din1;

  logic [PAD_W-1:0]      w_in_pad;
  logic [ADDR_WIDTH-1:0] w_in_a0;
  logic [ADDR_WIDTH-1:0] w_in_a1;
  logic                  w_in_use1;
  logic                  w_in_ins;
  logic [ADDR_WIDTH-1:0] w_nx_a0;
  logic [ADDR_WIDTH-1:0] w_nx_a1;
  logic                  w_nx_use1;
  logic                  w_acc_next;

  assign w_in_pad  = PAD_W'(bus.in_idx);
  assign w_in_a0   = w_in_pad[0 +: ADDR_WIDTH];
  assign w_in_a1   = w_in_pad[ADDR_WIDTH +: ADDR_WIDTH];
  assign w_in_use1 = (NUM_HASH > 1);
  assign w_in_ins  = (bus.in_op == 2'b01);
  assign w_nx_a0   = r_idx[0 +: ADDR_WIDTH];
  assign w_nx_a1   = r_idx[ADDR_WIDTH +: ADDR_WIDTH];
  // Only the final pass of an odd key leaves port 1 idle.
  assign w_nx_use1 = !(K_ODD && (r_cnt == CNT_W'(1)));
  assign w_acc_next = r_rd_vld ? (r_acc & bus.bram_dout0 & (bus.bram_dout1 | ~r_rd_use1))
                               : r_acc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_hit   <= 1'b0;
      r_out_op    <= 2'b00;
      r_op        <= 2'b00;
      r_ins       <= 1'b0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_acc       <= 1'b1;
      r_pass_vld  <= 1'b0;
      r_port1_vld <= 1'b0;
      r_rd_vld    <= 1'b0;
      r_rd_use1   <= 1'b0;
      r_addr0     <= '0;
      r_addr1     <= '0;
      r_we0       <= 1'b0;
      r_we1       <= 1'b0;
      r_din0      <= 1'b0;
      r_din1      <= 1'b0;
    end else begin
      r_rd_vld  <= r_pass_vld;
      r_rd_use1 <= r_port1_vld;
      r_acc     <= w_acc_next;
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_in_ready <= 1'b0;
            r_op       <= bus.in_op;
            r_acc      <= 1'b1;
            if (bus.in_op == 2'b10) begin
              r_state <= S_CLEAR;
              r_cnt   <= CLR_LAST;
              r_addr0 <= '0;
              r_addr1 <= ADDR_WIDTH'(1);
              r_we0   <= 1'b1;
              r_we1   <= 1'b1;
              r_din0  <= 1'b0;
              r_din1  <= 1'b0;
            end else begin
              r_state     <= S_ISSUE;
              r_ins       <= w_in_ins;
              r_cnt       <= PASS_LAST;
              r_idx       <= w_in_pad >> (2 * ADDR_WIDTH);
              r_pass_vld  <= 1'b1;
              r_port1_vld <= w_in_use1;
              r_addr0     <= w_in_a0;
              r_addr1     <= w_in_use1 ? w_in_a1 : '0;
              r_we0       <= w_in_ins;
              r_we1       <= w_in_ins & w_in_use1 & (w_in_a0 != w_in_a1);
              r_din0      <= w_in_ins;
              r_din1      <= w_in_ins & w_in_use1;
            end
          end
        end
        S_ISSUE: begin
          if (r_cnt == '0) begin
            r_state     <= S_WAIT;
            r_pass_vld  <= 1'b0;
            r_port1_vld <= 1'b0;
            r_addr0     <= '0;
            r_addr1     <= '0;
            r_we0       <= 1'b0;
            r_we1       <= 1'b0;
            r_din0      <= 1'b0;
            r_din1      <= 1'b0;
          end else begin
            r_cnt       <= r_cnt - CNT_W'(1);
            r_idx       <= r_idx >> (2 * ADDR_WIDTH);
            r_port1_vld <= w_nx_use1;
            r_addr0     <= w_nx_a0;
            r_addr1     <= w_nx_use1 ? w_nx_a1 : '0;
            r_we0       <= r_ins;
            r_we1       <= r_ins & w_nx_use1 & (w_nx_a0 != w_nx_a1);
            r_din0      <= r_ins;
            r_din1      <= r_ins & w_nx_use1;
          end
        end
        S_WAIT: begin
          r_state     <= S_RESP;
          r_out_valid <= 1'b1;
          r_out_hit   <= w_acc_next;
          r_out_op    <= r_op;
        end
        S_CLEAR: begin
          if (r_cnt == '0) begin
            r_state     <= S_RESP;
            r_out_valid <= 1'b1;
            r_out_hit   <= 1'b0;
            r_out_op    <= r_op;
            r_addr0     <= '0;
            r_addr1     <= '0;
            r_we0       <= 1'b0;
            r_we1       <= 1'b0;
          end else begin
            r_cnt   <= r_cnt - CNT_W'(1);
            r_addr0 <= r_addr0 + ADDR_WIDTH'(2);
            r_addr1 <= r_addr1 + ADDR_WIDTH'(2);
          end
        end
        S_RESP: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_hit    = r_out_hit;
  assign bus.out_op     = r_out_op;
  assign bus.bram_addr0 = r_addr0;
  assign bus.bram_addr1 = r_addr1;
  assign bus.bram_we0   = r_we0;
  assign bus.bram_we1   = r_we1;
  assign bus.bram_din0  = r_din0;
  assign bus.bram_din1  = r_din1;
endmodule
